// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
// Optional subtraction mode is enabled by defining BCD_SUB_EN.
package bcd_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;

  // Active-low segments, bit 0 = seg a ... bit 6 = seg g
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Glyph for one BCD digit; non-decimal codes show "E"
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > BCD_MAX) return SEG_E;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Handshake/operand/result bundle for bcd_serial_adder.
// With BCD_SUB_EN defined the bundle carries the extra 'sub' request bit.
//
// Handshake: 'start' is sampled only while the block is idle or showing
// done; when sampled high the operands are captured that same edge and
// 'busy' rises. 'start' during busy is dropped, never queued. 'done' is a
// one-cycle pulse marking sum/cout/err as valid; they hold until next start.
interface bcd_serial_adder_if #(parameter int DIGITS = 4);
  import bcd_serial_adder_pkg::*;

  logic                start;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic                cin;
`ifdef BCD_SUB_EN
  logic                sub;
`endif
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] sum;
  logic                cout;
  logic                err;
  logic [7*DIGITS-1:0] hex;
  state_t              dbg_state;

`ifdef BCD_SUB_EN
  modport master (output start, a, b, cin, sub,
                  input  busy, done, sum, cout, err, hex, dbg_state);
  modport slave  (input  start, a, b, cin, sub,
                  output busy, done, sum, cout, err, hex, dbg_state);
`else
  modport master (output start, a, b, cin,
                  input  busy, done, sum, cout, err, hex, dbg_state);
  modport slave  (input  start, a, b, cin,
                  output busy, done, sum, cout, err, hex, dbg_state);
`endif

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add (or nines-complement add for subtract).
// Invalid input digits force a zero digit and kill the carry.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  input  logic       sub_i,
  output logic [3:0] digit_o,
  output logic       carry_o,
  output logic       invalid_o
);

  logic [3:0] b_eff;
  logic [4:0] t;

  // Digit sum with decimal correction; validity judged on the raw b digit
  always_comb begin
    invalid_o = (a_i > BCD_MAX) || (b_i > BCD_MAX);
    b_eff     = sub_i ? (BCD_MAX - b_i) : b_i;
    t         = {1'b0, a_i} + {1'b0, b_eff} + {4'b0000, carry_i};
    digit_o   = t[3:0];
    carry_o   = 1'b0;
    if (invalid_o) begin
      digit_o = 4'd0;
      carry_o = 1'b0;
    end else if (t > 5'd9) begin
      digit_o = t[3:0] + 4'd6;
      carry_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, one digit per clock, with a
// registered seven-segment latch loaded when the result is retired.
// Define BCD_SUB_EN to add the 'sub' request (a - b via nines complement).
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  bcd_serial_adder_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [W-1:0]        a_q, b_q, sum_q;
  logic                carry_q, sub_q, cout_q, err_q, busy_q, done_q;
  logic [7*DIGITS-1:0] hex_q;

  logic                sub_in;
  logic [3:0]          a_dig, b_dig, dig_d;
  logic                carry_d, inv_d;

`ifdef BCD_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  assign a_dig = a_q[4*idx_q +: 4];
  assign b_dig = b_q[4*idx_q +: 4];

  bcd_digit_add u_digit (
    .a_i       (a_dig),
    .b_i       (b_dig),
    .carry_i   (carry_q),
    .sub_i     (sub_q),
    .digit_o   (dig_d),
    .carry_o   (carry_d),
    .invalid_o (inv_d)
  );

  // Control FSM plus operand, result and display registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= {DIGITS{SEG_ZERO}};
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          // Display latches the retired result as we leave DONE
          if (state_q == DONE) begin
            for (int i = 0; i < DIGITS; i++) begin
              hex_q[7*i +: 7] <= err_q ? SEG_E : seg_of(sum_q[4*i +: 4]);
            end
          end
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= sub_in;
            carry_q <= sub_in ? 1'b1 : bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= dig_d;
          carry_q             <= carry_d;
          if (inv_d) err_q <= 1'b1;
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
  assign bus.hex       = hex_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS = 4): directed cases,
// start-hold and mid-run reset, then randomized operations against a
// decimal reference model. Subtract cases run when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;
  import bcd_serial_adder_pkg::*;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic clk = 1'b0;
  logic resetn = 1'b1;

  bcd_serial_adder_if #(.DIGITS(D)) bus ();

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0]   exp_q[$];
  logic           hex_pending = 1'b0;
  logic [7*D-1:0] hex_exp;
  logic [6:0]     glyph [0:9];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Decimal reference: per-digit arithmetic with %10 and /10
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb,
                       output logic [W-1:0] s, output logic co, output logic e);
    int c, ad, bd, t;
    c = sb ? 1 : int'(ci);
    e = 1'b0;
    s = '0;
    for (int i = 0; i < D; i++) begin
      ad = int'(av[4*i +: 4]);
      bd = int'(bv[4*i +: 4]);
      if (ad > 9 || bd > 9) begin
        e = 1'b1;
        c = 0;
      end else begin
        if (sb) bd = 9 - bd;
        t = ad + bd + c;
        s[4*i +: 4] = 4'(t % 10);
        c = t / 10;
      end
    end
    co = (c != 0);
  endtask

  function automatic logic [7*D-1:0] exp_hex(input logic [W-1:0] s, input logic e);
    logic [7*D-1:0] h;
    for (int i = 0; i < D; i++)
      h[7*i +: 7] = e ? 7'b0000110 : glyph[int'(s[4*i +: 4])];
    return h;
  endfunction

  function automatic logic [W-1:0] rnd_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++)
      v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge after the done cycle is checked.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input logic hold);
    logic [W-1:0] es;
    logic ec, ee;
    model(av, bv, ci, sb, es, ec, ee);
    exp_q.push_back(es);
    bus.a = av;
    bus.b = bv;
    bus.cin = ci;
`ifdef BCD_SUB_EN
    bus.sub = sb;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("busy_e0", bus.busy, 1);
    check("done_e0", bus.done, 0);
    if (hex_pending) begin
      check("hex_b2b", bus.hex, hex_exp);
      hex_pending = 1'b0;
    end
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int k = 1; k <= D; k++) begin
      @(posedge clk); #1;
      if (k < D) begin
        check("busy_run", bus.busy, 1);
        check("done_run", bus.done, 0);
      end else begin
        check("done_pulse", bus.done, 1);
        check("busy_end", bus.busy, 0);
        check("sum", bus.sum, exp_q.pop_front());
        check("cout", bus.cout, ec);
        check("err", bus.err, ee);
      end
    end
    hex_pending = 1'b1;
    hex_exp = exp_hex(es, ee);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("done_idle", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    if (hex_pending) begin
      check("hex", bus.hex, hex_exp);
      hex_pending = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, bus.dbg_state, IDLE);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_sum"}, bus.sum, 0);
    check({tag, "_cout"}, bus.cout, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_hex"}, bus.hex, {D{7'b1000000}});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef BCD_SUB_EN
    bus.sub = 1'b0;
`endif
    #3 resetn = 1'b0;
    #2 check_reset_values("reset");
    @(negedge clk);
    resetn = 1'b1;
    idle_cycle();

    // Directed additions
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    run_op(16'h12A4, 16'h0000, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    run_op(16'h0042, 16'h0058, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    // start held high during RUN: no restart
    run_op(16'h0808, 16'h0707, 1'b1, 1'b0, 1'b1);
    idle_cycle();
    check("state_after_hold", bus.dbg_state, IDLE);

    // resetn dropped mid-run
    bus.a = 16'h4321;
    bus.b = 16'h1111;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_values("midrst");
    hex_pending = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < D + 2; k++) idle_cycle();
    check("midrst_sum_kept0", bus.sum, 0);

`ifdef BCD_SUB_EN
    run_op(16'h0500, 16'h0123, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    run_op(16'h0100, 16'h0200, 1'b1, 1'b1, 1'b0);
    idle_cycle();
`endif

    // Randomized operations, mixing back-to-back and idle gaps
    for (int n = 0; n < 40; n++) begin
      logic sb;
      sb = 1'b0;
`ifdef BCD_SUB_EN
      sb = 1'($urandom_range(0, 1));
`endif
      run_op(rnd_bcd(), rnd_bcd(), 1'($urandom_range(0, 1)), sb, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
